// File: rtl/image_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : image_write_arbiter
// Brief    : Per-source write FIFOs drained one beat per cycle onto the frame-buffer BRAM port.
// Revision : 1.0 - initial release
// ============================================================================
module image_write_arbiter #(
    parameter int               N_SRC        = 2,
    parameter int               ADDR_W       = 19,
    parameter int               DATA_W       = 8,
    parameter int               FRAME_PIXELS = 307200,
    parameter int               FIFO_DEPTH   = 4,
    parameter logic [N_SRC-1:0] STREAM_MASK  = 'b01,
    parameter int               RR_MODE      = 0
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic [N_SRC-1:0]          src_valid,
    input  logic [N_SRC*ADDR_W-1:0]   src_addr,
    input  logic [N_SRC*DATA_W-1:0]   src_data,
    output logic [N_SRC-1:0]          src_ready,
    input  logic                      stream_restart,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [2:0]                wr_src,
    output logic [N_SRC-1:0]          frame_done,
    output logic [N_SRC-1:0]          overflow
);

    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam int                 c_ENT_W = ADDR_W + DATA_W;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]  c_LAST  = ADDR_W'(FRAME_PIXELS - 1);

    logic [N_SRC-1:0]   w_nonempty;
    logic [c_ENT_W-1:0] w_head [N_SRC];

    logic               grant_vld_d;
    logic [2:0]         grant_idx_d;
    logic [c_ENT_W-1:0] grant_ent_d;

    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [DATA_W-1:0]  wr_data_q;
    logic [2:0]         wr_src_q;
    logic [2:0]         rr_ptr_q;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        logic [c_ENT_W-1:0] mem_q [FIFO_DEPTH];
        logic [c_PTR_W-1:0] wptr_q;
        logic [c_PTR_W-1:0] rptr_q;
        logic [c_CNT_W-1:0] count_q;
        logic [ADDR_W-1:0]  cnt_q;
        logic               fd_q;
        logic               ovf_q;
        logic               w_accept;
        logic               w_pop;
        logic [ADDR_W-1:0]  w_addr_in;

        // Readiness looks at the occupancy only, so a full FIFO refuses even while popping.
        assign src_ready[i]  = !reset && (count_q < c_DEPTH);
        assign w_accept      = src_valid[i] && src_ready[i];
        assign w_pop         = grant_vld_d && (grant_idx_d == 3'(i));
        assign w_addr_in     = STREAM_MASK[i] ? cnt_q : src_addr[i*ADDR_W +: ADDR_W];
        assign w_nonempty[i] = (count_q != '0);
        assign w_head[i]     = mem_q[rptr_q];
        assign frame_done[i] = fd_q;
        assign overflow[i]   = ovf_q;

        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                if (w_accept) wptr_q <= wptr_q + 1'b1;
                if (w_pop)    rptr_q <= rptr_q + 1'b1;
                if (w_accept && !w_pop)      count_q <= count_q + 1'b1;
                else if (!w_accept && w_pop) count_q <= count_q - 1'b1;
                if (src_valid[i] && !src_ready[i]) ovf_q <= 1'b1;
            end
        end

        always_ff @(posedge CLOCK_50) begin
            if (w_accept) mem_q[wptr_q] <= {w_addr_in, src_data[i*DATA_W +: DATA_W]};
        end

        // A restart overrides the increment but the beat still used the old address.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                cnt_q <= '0;
                fd_q  <= 1'b0;
            end else begin
                fd_q <= STREAM_MASK[i] && w_accept && (cnt_q == c_LAST);
                if (stream_restart)  cnt_q <= '0;
                else if (w_accept)   cnt_q <= (cnt_q == c_LAST) ? '0 : cnt_q + 1'b1;
            end
        end
    end

    // Round-robin: first look above the last grant, then wrap to the lowest index.
    always_comb begin
        grant_vld_d = 1'b0;
        grant_idx_d = '0;
        grant_ent_d = '0;
        if (RR_MODE != 0) begin
            for (int k = 0; k < N_SRC; k++) begin
                if (!grant_vld_d && w_nonempty[k] && (3'(k) > rr_ptr_q)) begin
                    grant_vld_d = 1'b1;
                    grant_idx_d = 3'(k);
                    grant_ent_d = w_head[k];
                end
            end
        end
        for (int k = 0; k < N_SRC; k++) begin
            if (!grant_vld_d && w_nonempty[k]) begin
                grant_vld_d = 1'b1;
                grant_idx_d = 3'(k);
                grant_ent_d = w_head[k];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= '0;
            rr_ptr_q  <= 3'(N_SRC - 1);
        end else begin
            wr_en_q <= grant_vld_d;
            if (grant_vld_d) begin
                wr_addr_q <= grant_ent_d[c_ENT_W-1 -: ADDR_W];
                wr_data_q <= grant_ent_d[DATA_W-1:0];
                wr_src_q  <= grant_idx_d;
                rr_ptr_q  <= grant_idx_d;
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_src  = wr_src_q;

endmodule
`default_nettype wire

// File: tb/tb_image_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_write_arbiter
// Brief    : Fixed-priority and round-robin instances checked against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_write_arbiter;
    localparam int AW = 19, DW = 8, FP = 8, DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    src_valid = '0;
    logic [2*AW-1:0] src_addr = '0;
    logic [2*DW-1:0] src_data = '0;
    logic          stream_restart = 1'b0;

    logic [1:0]    o_rdy  [2];
    logic          o_en   [2];
    logic [AW-1:0] o_addr [2];
    logic [DW-1:0] o_data [2];
    logic [2:0]    o_src  [2];
    logic [1:0]    o_fd   [2];
    logic [1:0]    o_ovf  [2];

    always #5 clk = ~clk;

    for (genvar m = 0; m < 2; m++) begin : g_dut
        image_write_arbiter #(
            .N_SRC(2), .ADDR_W(AW), .DATA_W(DW), .FRAME_PIXELS(FP),
            .FIFO_DEPTH(DEPTH), .STREAM_MASK(2'b01), .RR_MODE(m)
        ) u_dut (
            .CLOCK_50(clk), .reset(reset), .src_valid(src_valid), .src_addr(src_addr),
            .src_data(src_data), .src_ready(o_rdy[m]), .stream_restart(stream_restart),
            .wr_en(o_en[m]), .wr_addr(o_addr[m]), .wr_data(o_data[m]), .wr_src(o_src[m]),
            .frame_done(o_fd[m]), .overflow(o_ovf[m])
        );
    end

    int n_checks = 0, n_err = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: unbounded per-source queues, one pop per cycle chosen by the arbitration rule.
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t          mbuf [2][2][64];
    int            mhd [2][2], mtl [2][2];
    int            mcnt [2], mptr [2];
    logic          m_en [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    logic [2:0]    m_src [2];
    logic [1:0]    m_fd [2], m_ovf [2];
    int            cyc = 0;
    bit            chk_on = 1'b0;

    task automatic model_clear(input int m);
        for (int s = 0; s < 2; s++) begin mhd[m][s] = 0; mtl[m][s] = 0; end
        mcnt[m] = 0; mptr[m] = 1;
        m_en[m] = 1'b0; m_addr[m] = '0; m_data[m] = '0; m_src[m] = '0;
        m_fd[m] = '0; m_ovf[m] = '0;
    endtask

    task automatic model_step(input int m);
        int   g, s;
        int   sz [2];
        ent_t e;
        g = -1;
        for (int k = 0; k < 2; k++) sz[k] = mtl[m][k] - mhd[m][k];
        for (int off = 1; off <= 2; off++) begin
            s = (m == 0) ? off - 1 : (mptr[m] + off) % 2;
            if (g < 0 && sz[s] > 0) g = s;
        end
        m_fd[m] = '0;
        m_en[m] = (g >= 0);
        if (g >= 0) begin
            e = mbuf[m][g][mhd[m][g] % 64];
            mhd[m][g]++;
            m_addr[m] = e.a; m_data[m] = e.d; m_src[m] = 3'(g); mptr[m] = g;
        end
        for (int k = 0; k < 2; k++) begin
            if (src_valid[k]) begin
                if (sz[k] < DEPTH) begin
                    e.a = (k == 0) ? AW'(mcnt[m]) : src_addr[k*AW +: AW];
                    e.d = src_data[k*DW +: DW];
                    mbuf[m][k][mtl[m][k] % 64] = e;
                    mtl[m][k]++;
                    if (k == 0) begin
                        if (mcnt[m] == FP - 1) begin mcnt[m] = 0; m_fd[m][0] = 1'b1; end
                        else mcnt[m]++;
                    end
                end else begin
                    m_ovf[m][k] = 1'b1;
                end
            end
        end
        if (stream_restart) mcnt[m] = 0;
    endtask

    always @(posedge clk) begin
        cyc++;
        for (int m = 0; m < 2; m++) begin
            if (reset) model_clear(m);
            else model_step(m);
        end
    end

    typedef struct { int cyc; int src; int addr; int data; } wr_t;
    wr_t wlog0 [$], wlog1 [$];
    int  fdlog [$];

    always @(negedge clk) begin : compare
        logic [1:0] er;
        wr_t        w;
        if (chk_on) begin
            for (int m = 0; m < 2; m++) begin
                for (int s = 0; s < 2; s++) er[s] = !reset && (mtl[m][s] - mhd[m][s] < DEPTH);
                check($sformatf("d%0d_src_ready@%0d", m, cyc), o_rdy[m], er);
                check($sformatf("d%0d_wr_en@%0d", m, cyc), o_en[m], m_en[m]);
                check($sformatf("d%0d_wr_addr@%0d", m, cyc), o_addr[m], m_addr[m]);
                check($sformatf("d%0d_wr_data@%0d", m, cyc), o_data[m], m_data[m]);
                check($sformatf("d%0d_wr_src@%0d", m, cyc), o_src[m], m_src[m]);
                check($sformatf("d%0d_frame_done@%0d", m, cyc), o_fd[m], m_fd[m]);
                check($sformatf("d%0d_overflow@%0d", m, cyc), o_ovf[m], m_ovf[m]);
            end
            if (o_en[0] === 1'b1) begin
                w.cyc = cyc; w.src = int'(o_src[0]); w.addr = int'(o_addr[0]); w.data = int'(o_data[0]);
                wlog0.push_back(w);
            end
            if (o_en[1] === 1'b1) begin
                w.cyc = cyc; w.src = int'(o_src[1]); w.addr = int'(o_addr[1]); w.data = int'(o_data[1]);
                wlog1.push_back(w);
            end
            if (o_fd[0][0] === 1'b1) fdlog.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic v1,
                         input logic [AW-1:0] a1, input logic [7:0] d1, input logic rs);
        src_valid      = {v1, v0};
        src_addr       = {a1, {AW{1'b0}}};
        src_data       = {d1, d0};
        stream_restart = rs;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, '0, 8'h00, 1'b0);
    endtask

    task automatic clear_logs();
        wlog0.delete(); wlog1.delete(); fdlog.delete();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        int t0, n1;
        tick();
        chk_on = 1'b1;
        tick(); tick();
        check("rst_src_ready", o_rdy[0], 2'b00);
        check("rst_wr_en", o_en[0], 1'b0);
        check("rst_wr_addr", o_addr[0], '0);
        check("rst_overflow", o_ovf[0], 2'b00);
        reset = 1'b0;
        #1;
        check("release_src_ready", o_rdy[0], 2'b11);

        // Three stream beats: addresses 0..2, two-cycle latency.
        clear_logs();
        t0 = cyc;
        drive(1'b1, 8'hA1, 1'b0, '0, 8'h00, 1'b0);
        drive(1'b1, 8'hA2, 1'b0, '0, 8'h00, 1'b0);
        drive(1'b1, 8'hA3, 1'b0, '0, 8'h00, 1'b0);
        idle(5);
        check("t1_count", wlog0.size(), 3);
        if (wlog0.size() == 3) begin
            check("t1_first_latency", wlog0[0].cyc, t0 + 2);
            for (int k = 0; k < 3; k++) begin
                check($sformatf("t1_addr%0d", k), wlog0[k].addr, k);
                check($sformatf("t1_data%0d", k), wlog0[k].data, 8'hA1 + k);
                check($sformatf("t1_src%0d", k), wlog0[k].src, 0);
            end
        end

        // Nine beats after a restart: wrap after 7 and a single frame_done pulse.
        drive(1'b0, 8'h00, 1'b0, '0, 8'h00, 1'b1);
        clear_logs();
        t0 = cyc;
        for (int k = 0; k < 9; k++) drive(1'b1, 8'(8'h10 + k), 1'b0, '0, 8'h00, 1'b0);
        idle(5);
        check("t2_count", wlog0.size(), 9);
        if (wlog0.size() == 9)
            for (int k = 0; k < 9; k++) check($sformatf("t2_addr%0d", k), wlog0[k].addr, (k < 8) ? k : 0);
        check("t2_fd_pulses", fdlog.size(), 1);
        if (fdlog.size() == 1) check("t2_fd_cycle", fdlog[0], t0 + 8);

        // Fixed priority with both sources: source 0 drains first, source 1 fills.
        clear_logs();
        for (int k = 0; k < 4; k++)
            drive(1'b1, 8'(8'h30 + k), 1'b1, AW'(32'h100 + k), 8'h55, 1'b0);
        check("t3_src1_not_ready", o_rdy[0][1], 1'b0);
        idle(8);
        check("t3_no_overflow", o_ovf[0], 2'b00);
        check("t3_count", wlog0.size(), 8);
        if (wlog0.size() == 8) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t3_s0_src%0d", k), wlog0[k].src, 0);
                check($sformatf("t3_s0_addr%0d", k), wlog0[k].addr, 1 + k);
                check($sformatf("t3_s1_src%0d", k), wlog0[4+k].src, 1);
                check($sformatf("t3_s1_addr%0d", k), wlog0[4+k].addr, 32'h100 + k);
                check($sformatf("t3_s1_data%0d", k), wlog0[4+k].data, 8'h55);
            end
        end

        // Source 0 hogs the grants: 4 of 6 source-1 beats land, overflow sticks.
        clear_logs();
        for (int k = 0; k < 6; k++)
            drive(1'b1, 8'(8'h40 + k), 1'b1, AW'(32'h200 + k), 8'(8'h80 + k), 1'b0);
        idle(8);
        check("t5_overflow", o_ovf[0][1], 1'b1);
        n1 = 0;
        foreach (wlog0[j]) begin
            if (wlog0[j].src == 1) begin
                check($sformatf("t5_s1_addr%0d", n1), wlog0[j].addr, 32'h200 + n1);
                n1++;
            end
        end
        check("t5_s1_writes", n1, 4);
        idle(3);
        check("t5_overflow_sticky", o_ovf[0][1], 1'b1);

        // Round-robin from reset: strict alternation with no idle cycle.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        clear_logs();
        t0 = cyc;
        for (int k = 0; k < 3; k++)
            drive(1'b1, 8'(8'h70 + k), 1'b1, AW'(32'h300 + k), 8'(8'h90 + k), 1'b0);
        idle(6);
        check("t4_count", wlog1.size(), 6);
        if (wlog1.size() == 6)
            for (int k = 0; k < 6; k++) begin
                check($sformatf("t4_src%0d", k), wlog1[k].src, k % 2);
                check($sformatf("t4_cyc%0d", k), wlog1[k].cyc, t0 + 2 + k);
            end

        // Restart coincident with the accept at address 5.
        clear_logs();
        drive(1'b1, 8'h61, 1'b0, '0, 8'h00, 1'b0);
        drive(1'b1, 8'h62, 1'b0, '0, 8'h00, 1'b0);
        drive(1'b1, 8'h63, 1'b0, '0, 8'h00, 1'b1);
        drive(1'b1, 8'h64, 1'b0, '0, 8'h00, 1'b0);
        idle(5);
        check("t6_count", wlog0.size(), 4);
        if (wlog0.size() == 4)
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t6_addr%0d", k), wlog0[k].addr, (k < 3) ? 3 + k : 0);
                check($sformatf("t6_data%0d", k), wlog0[k].data, 8'h61 + k);
            end

        // Reset with entries pending: everything clears and nothing stale comes out.
        for (int k = 0; k < 3; k++)
            drive(1'b1, 8'(8'hE0 + k), 1'b1, AW'(32'h400 + k), 8'hEE, 1'b0);
        src_valid = '0;
        reset = 1'b1;
        tick();
        check("t6_rst_wr_en", o_en[0], 1'b0);
        check("t6_rst_wr_addr", o_addr[0], '0);
        check("t6_rst_wr_data", o_data[0], '0);
        check("t6_rst_wr_src", o_src[0], '0);
        check("t6_rst_src_ready", o_rdy[0], 2'b00);
        check("t6_rst_frame_done", o_fd[0], 2'b00);
        tick();
        reset = 1'b0;
        clear_logs();
        #1;
        check("t6_release_ready0", o_rdy[0], 2'b11);
        check("t6_release_ready1", o_rdy[1], 2'b11);
        idle(6);
        check("t6_no_stale0", wlog0.size(), 0);
        check("t6_no_stale1", wlog1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/image_write_arbiter.md
Name: image_write_arbiter

Overview:
Parametrised multi-source write arbiter for the image frame buffer, placed between the pixel sources (UART stream, cursor painter, future sources) and the BRAM write port. It replaces the fixed UART-over-cursor mux, which silently lost colliding writes. Each source gets a small FIFO; an arbiter then drains the FIFOs one write per cycle. Stream-mode sources get internal frame address counters with wrap and a frame-done pulse.

Parameters:
N_SRC, 2, number of write sources (1..8)
ADDR_W, 19, BRAM address width
DATA_W, 8, pixel width
FRAME_PIXELS, 307200, pixels per frame; stream counters wrap at FRAME_PIXELS-1
FIFO_DEPTH, 4, entries per source FIFO (power of 2, >=2)
STREAM_MASK, 'b01, bit i=1: source i ignores src_addr and uses its internal counter
RR_MODE, 0, 0=fixed priority (lowest index wins), 1=round-robin

Ports:
CLOCK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
src_valid  in  N_SRC  per-source write request
src_addr  in  N_SRC*ADDR_W  per-source address, source i at [i*ADDR_W +: ADDR_W]; ignored for stream sources
src_data  in  N_SRC*DATA_W  per-source pixel, same packing as src_addr
src_ready  out  N_SRC  source FIFO not full
stream_restart  in  1  pulse: all stream counters go to 0
wr_en  out  1  BRAM write enable
wr_addr  out  ADDR_W  BRAM write address
wr_data  out  DATA_W  BRAM write data
wr_src  out  3  index of the source granted for the current wr_en
frame_done  out  N_SRC  1-cycle pulse when a stream source's last pixel is enqueued
overflow  out  N_SRC  sticky flag: a write was dropped because the FIFO was full

Behaviour:
- Reset: all FIFOs empty, all counters 0, RR pointer = N_SRC-1, and every output 0. This includes src_ready=0 while reset is high.
- Reset in mid-operation: discards pending FIFO contents with no further wr_en; src_ready returns to 1 on the first cycle after reset deasserts.
- Accept: a beat is accepted when src_valid[i] & src_ready[i] at a rising edge.
  - src_ready[i] = (count_i < FIFO_DEPTH). It is computed from count only, so a full FIFO stays not-ready even in a cycle where it pops.
- Drop: src_valid[i] with FIFO i full drops the beat and sets overflow[i]. overflow clears only on reset.
- Stream address: the FIFO stores {addr, data}. For stream source i the stored addr is cnt_i, and cnt_i increments on every accept.
  - Wrap: an accept at cnt_i = FRAME_PIXELS-1 stores that address, sets cnt_i to 0, and registers frame_done[i]=1 for exactly the next cycle.
- stream_restart: forces all cnt_i to 0. A beat accepted in the same cycle uses the pre-restart address, and restart then wins (counter = 0, no increment). FIFOs are not flushed.
- Arbitration: each cycle, one grant is made combinationally among non-empty FIFOs.
  - RR_MODE=0: lowest index wins.
  - RR_MODE=1: search starts at (last_grant+1) mod N_SRC; the pointer updates only on a grant.
- Output and pop: on the edge after a grant, the granted FIFO head is popped and registered onto wr_addr/wr_data/wr_src with wr_en=1.
  - With no grant, wr_en=0 and wr_addr/wr_data/wr_src hold their last values.
- Throughput: maximum 1 write per cycle total.
- Latency: a beat accepted at edge E into an empty FIFO with no contention appears with wr_en=1 in the cycle after edge E+1, i.e. 2 cycles from its src_valid cycle.
- Ordering: writes from a single source reach wr_* in acceptance order. There is no ordering guarantee across sources.
- Address collision: two sources writing the same address both complete, in grant order; the last write wins in BRAM.
- Width rules: counters are ADDR_W bits and FRAME_PIXELS must be <= 2**ADDR_W. FIFO pointers are log2(FIFO_DEPTH) bits and count is log2(FIFO_DEPTH)+1 bits.

Test Plan:
1. N_SRC=2, STREAM_MASK=01, FRAME_PIXELS=8: source 0 sends data 0xA1, 0xA2, 0xA3 on consecutive cycles -> wr_en for 3 cycles with wr_addr 0,1,2 / wr_data A1,A2,A3 / wr_src 0, with the first wr_en 2 cycles after the first src_valid.
2. Same config, 9 stream beats -> addresses 0..7 then 0; frame_done[0] high for exactly 1 cycle, the cycle after the 8th accept.
3. RR_MODE=0: both sources valid for 4 cycles (src1 addr 0x100.., data 0x55) -> all source-0 writes drain first, then source 1. Source 1 FIFO fills, src_ready[1]=0, overflow[1] stays 0 if the bench honours ready.
4. RR_MODE=1, both FIFOs preloaded with 3 entries -> wr_src sequence 0,1,0,1,0,1 with no idle cycle.
5. FIFO_DEPTH=4: source 1 drives src_valid for 6 cycles while source 0 hogs the grants (RR_MODE=0) -> 4 accepted, 2 dropped, overflow[1]=1 and sticky.
6. stream_restart at cnt_0=5 coincident with an accept -> that beat writes addr 5 and the next beat writes addr 0. Then reset asserted with entries pending -> wr_en=0, all outputs 0, no stale writes after release.
